display_arbiter: RTL

Shares the 4-digit seven-segment display between up to `NUM_REQ` requesters, e.g. CPU debug port, bus monitor, and fault reporter. Uses a level request/grant handshake with round-robin ownership and a guaranteed minimum hold time. The owner's 16-bit value and decimal points are encoded to four hex glyphs. These glyphs drive the `segment_data0..3` inputs of the display scanning multiplexer. When no requester is active, all digits are blank.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/hex_to_seg7.sv | 12 +
 rtl/display_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display arbiter: arbitration states,
// the blank glyph and the active-low hex glyph table (bit0=a ... bit6=g).
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FREE
    } arb_state_t;

    localparam logic [7:0] SEG7_BLANK = 8'hFF;

    // Segments a..g only; the dp bit is added by the encoder.
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph; dp_i=1 lights the point.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, SEG7_GLYPH[nibble_i]};

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing a 4-digit seven-segment display between requesters,
// with a minimum hold time per grant and registered glyph outputs.
module display_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_value,
    input  logic [4*NUM_REQ-1:0]   req_dp,
    output logic [NUM_REQ-1:0]     grant,
    output logic [2:0]             owner,
    output logic [7:0]             segment_data0,
    output logic [7:0]             segment_data1,
    output logic [7:0]             segment_data2,
    output logic [7:0]             segment_data3
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    function automatic logic [2:0] succ(input logic [2:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? 3'd0 : idx + 3'd1;
    endfunction

    // First set bit of mask at or after start, searching upward with wrap.
    function automatic pick_t rr_find(input logic [NUM_REQ-1:0] mask, input logic [2:0] start);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(start) + k) % NUM_REQ;
            if (!p.found && mask[j]) begin
                p.found = 1'b1;
                p.idx   = 3'(j);
            end
        end
        return p;
    endfunction

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]    cnt_q, cnt_d;
    logic [7:0]           seg_q [4];
    logic [7:0]           seg_d [4];
    logic [7:0]           glyph [4];

    logic                 owner_req;
    logic [NUM_REQ-1:0]   others;
    pick_t                idle_pick, hand_pick;
    logic                 handover, take_en;
    logic [2:0]           take_idx;
    logic [15:0]          owner_value;
    logic [3:0]           owner_dp;

    assign owner_req = |(grant_q & req);
    assign others    = req & ~grant_q;
    assign idle_pick = rr_find(req, rr_ptr_q);
    // The owner is masked out, so a handover can never re-grant the same requester.
    assign hand_pick = rr_find(others, succ(owner_q));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        handover = 1'b0;
        take_en  = 1'b0;
        take_idx = '0;

        case (state_q)
            IDLE: begin
                take_en  = idle_pick.found;
                take_idx = idle_pick.idx;
            end
            HOLD: begin
                if (!owner_req) begin
                    handover = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = FREE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FREE: begin
                handover = !owner_req || (others != '0);
            end
            default: state_d = IDLE;
        endcase

        if (handover) begin
            if (hand_pick.found) begin
                take_en  = 1'b1;
                take_idx = hand_pick.idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
            end
        end

        if (take_en) begin
            state_d  = HOLD;
            grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << take_idx;
            owner_d  = take_idx;
            rr_ptr_d = succ(take_idx);
            cnt_d    = HOLD_LOAD;
        end
    end

    always_comb begin
        owner_value = '0;
        owner_dp    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                owner_value = req_value[16*i +: 16];
                owner_dp    = req_dp[4*i +: 4];
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        hex_to_seg7 u_hex (
            .nibble_i (owner_value[4*gi +: 4]),
            .dp_i     (owner_dp[gi]),
            .seg_o    (glyph[gi])
        );
        assign seg_d[gi] = (grant_q != '0) ? glyph[gi] : SEG7_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < 4; i++) seg_q[i] <= SEG7_BLANK;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 4; i++) seg_q[i] <= seg_d[i];
        end
    end

    assign grant         = grant_q;
    assign owner         = owner_q;
    assign segment_data0 = seg_q[0];
    assign segment_data1 = seg_q[1];
    assign segment_data2 = seg_q[2];
    assign segment_data3 = seg_q[3];

endmodule
